// File: rtl/inst_fetch_responder_pkg.sv
// Shared definitions for the instruction fetch responder.
//   EXCCODE_ADEF  exception code reported for a misaligned fetch address
//   LINE_WORDS    32-bit words per 16-byte fetch line
//   fill_state_e  fill FSM state encodings
//   resp_count    inst_count value (words returned minus 1) for an aligned address
package inst_fetch_responder_pkg;

  localparam logic [5:0] EXCCODE_ADEF = 6'h08;
  localparam int         LINE_WORDS   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RESP  = 2'd3
  } fill_state_e;

  // Reads stop at the end of the 16-byte line, so the number of words is
  // 4 - addr[3:2]; the count field carries that number minus one.
  function automatic logic [1:0] resp_count(input logic [31:0] addr);
    return 2'd3 - addr[3:2];
  endfunction

endpackage

// File: rtl/inst_fetch_responder_req_fifo.sv
// Request queue for the fetch responder: a synchronous FIFO of byte addresses.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   push, push_addr   write an accepted request address
//   pop, head_addr    remove the head entry; head_addr shows the head entry
//   flush             discard all entries (wins over push and pop)
//   full, empty       occupancy flags, derived from the registered pointers
module inst_req_fifo
  import inst_fetch_responder_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic [31:0] push_addr,
  input  logic        pop,
  output logic [31:0] head_addr,
  input  logic        flush,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0] mem_reg [DEPTH];
  // One extra pointer bit tells full apart from empty.
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop && !empty) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !flush) begin
      mem_reg[wr_ptr_reg[AW-1:0]] <= push_addr;
    end
  end

  assign head_addr = mem_reg[rd_ptr_reg[AW-1:0]];
  assign empty     = (wr_ptr_reg == rd_ptr_reg);
  assign full      = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

endmodule

// File: rtl/inst_fetch_responder.sv
// Memory-side responder for the instruction fetch port. Queues IFU requests,
// reads up to four words (to the end of the 16-byte line) from a word-wide
// 1-cycle-latency RAM, and returns them as one 128-bit response.
// Ports:
//   clk, reset                     clock and synchronous active-high reset
//   inst_req, inst_addr            fetch request and byte address
//   inst_cancel                    flush every accepted and pending request
//   inst_addr_ok                   request accepted this cycle
//   inst_valid                     one-cycle response pulse
//   inst_rdata, inst_count         data (first word in [31:0]) and word count - 1
//   inst_uncache                   response address lies in the uncached window
//   inst_exception, inst_exccode   misaligned-address exception (ADEF)
//   ram_en, ram_addr, ram_rdata    instruction RAM read port
module inst_fetch_responder
  import inst_fetch_responder_pkg::*;
#(
  parameter int          REQ_DEPTH = 2,
  parameter int          RAM_AW    = 14,
  parameter logic [31:0] UNC_BASE  = 32'h1fc00000,
  parameter logic [31:0] UNC_MASK  = 32'hfff00000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_req,
  input  logic [31:0]       inst_addr,
  input  logic              inst_cancel,
  output logic              inst_addr_ok,
  output logic              inst_valid,
  output logic [127:0]      inst_rdata,
  output logic [1:0]        inst_count,
  output logic              inst_uncache,
  output logic              inst_exception,
  output logic [5:0]        inst_exccode,
  output logic              ram_en,
  output logic [RAM_AW-1:0] ram_addr,
  input  logic [31:0]       ram_rdata
);

  fill_state_e state_reg, state_next;

  logic        fifo_full;
  logic        fifo_empty;
  logic [31:0] fifo_head;
  logic        pop;
  logic        head_misaligned;

  logic [31:0] addr_reg;
  logic [1:0]  ptr_reg;         // word within the line being issued
  logic [1:0]  lane_reg;        // response lane of the word being issued
  logic        rd_pending_reg;  // a RAM word arrives this cycle
  logic [1:0]  rd_lane_reg;     // lane that arriving word belongs to
  logic        exc_reg;
  logic [1:0]  count_reg;
  logic [LINE_WORDS*32-1:0] rdata_packed;

  // Accept only against the registered full flag: a same-cycle pop does not
  // free a slot for the incoming request.
  assign inst_addr_ok    = inst_req & ~fifo_full & ~inst_cancel & ~reset;
  assign pop             = (state_reg == ST_IDLE) && !fifo_empty && !inst_cancel;
  assign head_misaligned = (fifo_head[1:0] != 2'b00);

  inst_req_fifo #(
    .DEPTH(REQ_DEPTH)
  ) u_req_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (inst_addr_ok),
    .push_addr(inst_addr),
    .pop      (pop),
    .head_addr(fifo_head),
    .flush    (inst_cancel),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    if (inst_cancel) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:  if (!fifo_empty) state_next = head_misaligned ? ST_RESP : ST_READ;
        ST_READ:  if (ptr_reg == 2'd3) state_next = ST_DRAIN;
        ST_DRAIN: state_next = ST_RESP;
        ST_RESP:  state_next = ST_IDLE;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // Output logic; response fields are held at zero outside the valid pulse.
  always_comb begin
    ram_en         = (state_reg == ST_READ);
    ram_addr       = ram_en ? {addr_reg[RAM_AW+1:4], ptr_reg} : '0;
    inst_valid     = (state_reg == ST_RESP) && !inst_cancel;
    inst_rdata     = inst_valid ? rdata_packed : '0;
    inst_count     = inst_valid ? count_reg : 2'd0;
    inst_exception = inst_valid && exc_reg;
    inst_exccode   = (inst_valid && exc_reg) ? EXCCODE_ADEF : 6'h00;
    inst_uncache   = inst_valid && ((addr_reg & UNC_MASK) == UNC_BASE);
  end

  // Fill bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_reg       <= '0;
      ptr_reg        <= '0;
      lane_reg       <= '0;
      rd_pending_reg <= 1'b0;
      rd_lane_reg    <= '0;
      exc_reg        <= 1'b0;
      count_reg      <= '0;
    end else begin
      // A read issued in the cancel cycle is never captured.
      rd_pending_reg <= (state_reg == ST_READ) && !inst_cancel;
      rd_lane_reg    <= lane_reg;
      if (pop) begin
        addr_reg  <= fifo_head;
        ptr_reg   <= fifo_head[3:2];
        lane_reg  <= 2'd0;
        exc_reg   <= head_misaligned;
        count_reg <= head_misaligned ? 2'd0 : resp_count(fifo_head);
      end else if (state_reg == ST_READ) begin
        ptr_reg  <= ptr_reg + 2'd1;
        lane_reg <= lane_reg + 2'd1;
      end
    end
  end

  // Response lanes; cleared at each pop so lanes past the line end read as 0.
  genvar gi;
  generate
    for (gi = 0; gi < LINE_WORDS; gi++) begin : g_lane
      logic [31:0] word_reg;
      always_ff @(posedge clk) begin
        if (reset || inst_cancel || pop) begin
          word_reg <= '0;
        end else if (rd_pending_reg && (rd_lane_reg == 2'(gi))) begin
          word_reg <= ram_rdata;
        end
      end
      assign rdata_packed[gi*32 +: 32] = word_reg;
    end
  endgenerate

endmodule

// File: tb/tb_inst_fetch_responder.sv
module tb_inst_fetch_responder;

  localparam int          RAM_AW    = 14;
  localparam int          RAM_WORDS = 1 << RAM_AW;
  localparam logic [31:0] UNC_BASE  = 32'h1fc00000;
  localparam logic [31:0] UNC_MASK  = 32'hfff00000;

  logic              clk = 1'b0;
  logic              reset;
  logic              inst_req;
  logic [31:0]       inst_addr;
  logic              inst_cancel;
  logic              inst_addr_ok;
  logic              inst_valid;
  logic [127:0]      inst_rdata;
  logic [1:0]        inst_count;
  logic              inst_uncache;
  logic              inst_exception;
  logic [5:0]        inst_exccode;
  logic              ram_en;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_rdata;

  logic [31:0] mem [RAM_WORDS];
  logic [31:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int nresp  = 0;

  typedef struct {
    logic [31:0] addr;
    int          lat;
    int          reads;
    logic [1:0]  count;
    logic        exc;
    logic        unc;
  } vec_t;
  vec_t vecs [8];

  inst_fetch_responder #(
    .REQ_DEPTH(2),
    .RAM_AW   (RAM_AW),
    .UNC_BASE (UNC_BASE),
    .UNC_MASK (UNC_MASK)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .inst_req      (inst_req),
    .inst_addr     (inst_addr),
    .inst_cancel   (inst_cancel),
    .inst_addr_ok  (inst_addr_ok),
    .inst_valid    (inst_valid),
    .inst_rdata    (inst_rdata),
    .inst_count    (inst_count),
    .inst_uncache  (inst_uncache),
    .inst_exception(inst_exception),
    .inst_exccode  (inst_exccode),
    .ram_en        (ram_en),
    .ram_addr      (ram_addr),
    .ram_rdata     (ram_rdata)
  );

  always #5 clk = ~clk;

  // Word-wide RAM with one cycle of read latency; junk when not enabled.
  always @(posedge clk) begin
    if (ram_en) ram_rdata <= mem[ram_addr];
    else        ram_rdata <= $urandom;
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: a response holds the words from the address to the end of
  // its 16-byte line, lowest first; misaligned addresses return nothing.
  function automatic logic [127:0] exp_rdata(input logic [31:0] a);
    logic [127:0] r;
    int n;
    int unsigned widx;
    r = '0;
    if (a[1:0] != 2'b00) return r;
    n = 4 - int'(a[3:2]);
    for (int i = 0; i < n; i++) begin
      widx = ((a >> 2) + i) & (RAM_WORDS - 1);
      r[i*32 +: 32] = mem[widx];
    end
    return r;
  endfunction

  task automatic check_resp(input logic [31:0] a);
    logic mis;
    int n;
    mis = (a[1:0] != 2'b00);
    n   = mis ? 1 : 4 - int'(a[3:2]);
    check("rdata", inst_rdata, exp_rdata(a));
    check("count", 128'(inst_count), 128'(n - 1));
    check("exception", 128'(inst_exception), 128'(mis));
    check("exccode", 128'(inst_exccode), mis ? 128'h08 : 128'h00);
    check("uncache", 128'(inst_uncache), 128'((a & UNC_MASK) == UNC_BASE));
    $display("resp addr=%h count=%0d exc=%0d unc=%0d", a, inst_count, inst_exception, inst_uncache);
  endtask

  // Scoreboard step, called once per cycle at the falling edge.
  task automatic sample_cycle();
    if (reset) begin
      exp_q.delete();
    end else if (inst_cancel) begin
      check("cancel_valid_mask", 128'(inst_valid), 128'(0));
      check("cancel_no_accept", 128'(inst_addr_ok), 128'(0));
      exp_q.delete();
    end else begin
      if (inst_valid) begin
        nresp++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp got valid addr-less response expected none");
        end else begin
          check_resp(exp_q.pop_front());
        end
      end
      if (inst_addr_ok) begin
        check("accept_needs_req", 128'(inst_req), 128'(1));
        exp_q.push_back(inst_addr);
      end
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    inst_req    = 1'b0;
    inst_cancel = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sample_cycle();
      next_cycle();
    end
  endtask

  // One request from idle: checks acceptance, latency, RAM reads and fields.
  task automatic run_single(input vec_t v);
    int lat, nvalid, nreads;
    lat = -1; nvalid = 0; nreads = 0;
    inst_req  = 1'b1;
    inst_addr = v.addr;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (c == 0) check("single_accept", 128'(inst_addr_ok), 128'(1));
      if (inst_valid) begin
        if (lat < 0) begin
          lat = c;
          check("single_rdata", inst_rdata, exp_rdata(v.addr));
          check("single_count", 128'(inst_count), 128'(v.count));
          check("single_exc", 128'(inst_exception), 128'(v.exc));
          check("single_exccode", 128'(inst_exccode), v.exc ? 128'h08 : 128'h00);
          check("single_uncache", 128'(inst_uncache), 128'(v.unc));
        end
        nvalid++;
      end
      if (ram_en) nreads++;
      next_cycle();
      inst_req = 1'b0;
    end
    check("single_latency", 128'(lat), 128'(v.lat));
    check("single_pulses", 128'(nvalid), 128'(1));
    check("single_ram_reads", 128'(nreads), 128'(v.reads));
    $display("single addr=%h latency=%0d reads=%0d", v.addr, lat, nreads);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] base, a;
    case ($urandom_range(0, 2))
      0:       base = 32'h1c000000;
      1:       base = 32'h1fc00000;
      default: base = 32'h1fd00000;
    endcase
    a = base | (32'($urandom_range(0, 1023)) << 2);
    if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  initial begin
    logic [31:0] b2b_addrs [4];
    int idx, resp0, wd;

    for (int i = 0; i < RAM_WORDS; i++) mem[i] = $urandom;

    vecs[0] = '{32'h1c000000, 7, 4, 2'd3, 1'b0, 1'b0};
    vecs[1] = '{32'h1c00000c, 4, 1, 2'd0, 1'b0, 1'b0};
    vecs[2] = '{32'h1c000002, 2, 0, 2'd0, 1'b1, 1'b0};
    vecs[3] = '{32'h1c000004, 6, 3, 2'd2, 1'b0, 1'b0};
    vecs[4] = '{32'h1c000008, 5, 2, 2'd1, 1'b0, 1'b0};
    vecs[5] = '{32'h1fc00000, 7, 4, 2'd3, 1'b0, 1'b1};
    vecs[6] = '{32'h1fc00013, 2, 0, 2'd0, 1'b1, 1'b1};
    vecs[7] = '{32'h1fd00000, 7, 4, 2'd3, 1'b0, 1'b0};

    // Reset: a request held during reset must not be accepted.
    reset = 1'b1; inst_req = 1'b1; inst_addr = 32'h1c000000; inst_cancel = 1'b0;
    next_cycle();
    @(negedge clk);
    check("reset_no_accept", 128'(inst_addr_ok), 128'(0));
    next_cycle();
    reset = 1'b0; inst_req = 1'b0;
    @(negedge clk);
    check("reset_valid", 128'(inst_valid), 128'(0));
    check("reset_rdata", inst_rdata, 128'(0));
    check("reset_ram_en", 128'(ram_en), 128'(0));
    check("reset_exception", 128'(inst_exception), 128'(0));
    next_cycle();
    idle(3);

    // Table-driven single requests.
    for (int i = 0; i < 8; i++) run_single(vecs[i]);

    // Back-to-back with a two-entry queue: acceptance stalls while full.
    b2b_addrs[0] = 32'h1c000010; b2b_addrs[1] = 32'h1c000024;
    b2b_addrs[2] = 32'h1fc00038; b2b_addrs[3] = 32'h1c00004c;
    idx = 0; resp0 = nresp;
    inst_req = 1'b1; inst_addr = b2b_addrs[0];
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (c == 3) check("b2b_full_stall", 128'(inst_addr_ok), 128'(0));
      if (inst_req && inst_addr_ok) idx++;
      sample_cycle();
      next_cycle();
      if (idx < 4) inst_addr = b2b_addrs[idx];
      else         inst_req  = 1'b0;
    end
    check("b2b_responses", 128'(nresp - resp0), 128'(4));
    check("b2b_drained", 128'(exp_q.size()), 128'(0));

    // Cancel during READ with a second request queued.
    resp0 = nresp;
    for (int c = 0; c < 16; c++) begin
      inst_req = 1'b0; inst_cancel = 1'b0;
      if (c == 0) begin inst_req = 1'b1; inst_addr = 32'h1c000000; end
      if (c == 1) begin inst_req = 1'b1; inst_addr = 32'h1c000020; end
      if (c == 3) begin inst_cancel = 1'b1; inst_req = 1'b1; inst_addr = 32'h1c000070; end
      @(negedge clk);
      if (c == 4) check("cancel_ram_en_off", 128'(ram_en), 128'(0));
      sample_cycle();
      next_cycle();
    end
    check("cancel_no_resp", 128'(nresp - resp0), 128'(0));
    resp0 = nresp;
    inst_req = 1'b1; inst_addr = 32'h1c000034;
    @(negedge clk);
    sample_cycle();
    next_cycle();
    idle(12);
    check("after_cancel_resp", 128'(nresp - resp0), 128'(1));
    check("after_cancel_drained", 128'(exp_q.size()), 128'(0));

    // Reset during DRAIN abandons the fill.
    resp0 = nresp;
    for (int c = 0; c < 8; c++) begin
      inst_req = (c == 0); inst_addr = 32'h1c000000; reset = (c == 6);
      @(negedge clk);
      if (c == 7) begin
        check("rst_drain_valid", 128'(inst_valid), 128'(0));
        check("rst_drain_rdata", inst_rdata, 128'(0));
        check("rst_drain_count", 128'(inst_count), 128'(0));
        check("rst_drain_ram_en", 128'(ram_en), 128'(0));
        check("rst_drain_ram_addr", 128'(ram_addr), 128'(0));
        check("rst_drain_addr_ok", 128'(inst_addr_ok), 128'(0));
      end
      sample_cycle();
      next_cycle();
    end
    reset = 1'b0;
    idle(12);
    check("rst_drain_no_resp", 128'(nresp - resp0), 128'(0));
    run_single(vecs[0]);

    // Randomized traffic against the scoreboard.
    wd = 0;
    for (int c = 0; c < 1500; c++) begin
      inst_req    = $urandom_range(0, 1) == 1;
      inst_addr   = rand_addr();
      inst_cancel = $urandom_range(0, 29) == 0;
      @(negedge clk);
      sample_cycle();
      if (exp_q.size() != 0 && !inst_valid) wd++;
      else wd = 0;
      if (wd > 40) begin
        checks++;
        errors++;
        $display("FAIL resp_timeout got no response for %0d cycles expected one", wd);
        wd = 0;
      end
      next_cycle();
    end
    idle(40);
    check("random_drained", 128'(exp_q.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
